// File: rtl/sample_rom_scheduler.sv
// sample_rom_scheduler
// Time-multiplexes one sample ROM across NVOICES voice slots. Each audio
// frame (started by sample_tick) issues one ROM read per voice, waits out
// the ROM latency, then publishes every voice's sample at once with a
// one-cycle done pulse. Ticks that arrive while a frame is still running
// are dropped and flagged in the sticky overrun bit.

module sample_rom_scheduler #(
    parameter int NVOICES = 4,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_tick,
    input  logic [NVOICES*AW-1:0]  voice_addr,
    input  logic [NVOICES-1:0]     voice_active,
    input  logic                   clr_overrun,
    output logic [AW-1:0]          rom_addr,
    output logic                   rom_en,
    input  logic [DW-1:0]          rom_data,
    output logic [NVOICES*DW-1:0]  voice_data,
    output logic                   done,
    output logic                   busy,
    output logic                   overrun
);

    localparam int SW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam int CW = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [AW-1:0]        snap_addr   [NVOICES];
    logic [NVOICES-1:0]   snap_active;
    logic [DW-1:0]        shadow      [NVOICES];
    logic [DW-1:0]        shadow_next [NVOICES];
    logic [ROM_LAT:0]     en_pipe;
    logic [SW-1:0]        slot_pipe   [ROM_LAT+1];
    logic [SW-1:0]        next_slot;
    logic                 drop;

    // A tick is only dropped when a frame is already in flight.
    assign drop = sample_tick && (state != IDLE);

    // Slot that the following ISSUE cycle will address.
    assign next_slot = cnt[SW-1:0] + 1'b1;

    // Shadow registers with this cycle's returning ROM word merged in, so the
    // last slot's data can be published on the same edge that captures it.
    always_comb begin
        shadow_next = shadow;
        if (en_pipe[ROM_LAT]) begin
            shadow_next[slot_pipe[ROM_LAT]] = rom_data;
        end
    end

    // Frame sequencer, ROM request generation, read-return tracking and
    // output publication, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rom_addr    <= '0;
            rom_en      <= 1'b0;
            voice_data  <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            snap_active <= '0;
            en_pipe     <= '0;
            for (int k = 0; k < NVOICES; k++) begin
                snap_addr[k] <= '0;
                shadow[k]    <= '0;
            end
            for (int j = 0; j <= ROM_LAT; j++) begin
                slot_pipe[j] <= '0;
            end
        end else begin
            done       <= 1'b0;
            en_pipe[0] <= 1'b0;
            slot_pipe[0] <= '0;
            for (int j = 1; j <= ROM_LAT; j++) begin
                en_pipe[j]   <= en_pipe[j-1];
                slot_pipe[j] <= slot_pipe[j-1];
            end
            for (int k = 0; k < NVOICES; k++) begin
                shadow[k] <= shadow_next[k];
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state       <= ISSUE;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        snap_active <= voice_active;
                        for (int k = 0; k < NVOICES; k++) begin
                            snap_addr[k] <= voice_addr[k*AW +: AW];
                            shadow[k]    <= '0;
                        end
                        rom_en       <= voice_active[0];
                        rom_addr     <= voice_active[0] ? voice_addr[AW-1:0] : '0;
                        en_pipe[0]   <= voice_active[0];
                        slot_pipe[0] <= '0;
                    end
                end
                ISSUE: begin
                    if (cnt == CW'(NVOICES - 1)) begin
                        state    <= DRAIN;
                        cnt      <= '0;
                        rom_en   <= 1'b0;
                        rom_addr <= '0;
                    end else begin
                        cnt          <= cnt + 1'b1;
                        rom_en       <= snap_active[next_slot];
                        rom_addr     <= snap_active[next_slot] ? snap_addr[next_slot] : '0;
                        en_pipe[0]   <= snap_active[next_slot];
                        slot_pipe[0] <= next_slot;
                    end
                end
                DRAIN: begin
                    if (cnt == CW'(ROM_LAT - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                        for (int k = 0; k < NVOICES; k++) begin
                            voice_data[k*DW +: DW] <= shadow_next[k];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_rom_scheduler.sv
// tb_sample_rom_scheduler
// Runs two schedulers side by side from shared stimulus: one with default
// parameters and one with NVOICES=2, ROM_LAT=3. Each has its own latency-
// accurate ROM model. Expected bus activity, done timing, voice data and
// overrun are derived per frame from the frame's inputs.

module tb_sample_rom_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [63:0] voice_addr = '0;
    logic [3:0]  voice_active = '0;
    logic        clr_overrun = 1'b0;

    logic [15:0] rom_addr0, rom_addr1;
    logic        rom_en0, rom_en1;
    logic [7:0]  rom_data0, rom_data1;
    logic [31:0] voice_data0;
    logic [15:0] voice_data1;
    logic        done0, done1, busy0, busy1, overrun0, overrun1;

    int test_count = 0;
    int fail_count = 0;

    int          nv [2] = '{4, 2};
    int          lat [2] = '{1, 3};
    logic [63:0] last_voice [2] = '{64'd0, 64'd0};
    logic        exp_ov [2] = '{1'b0, 1'b0};

    sample_rom_scheduler #(.NVOICES(4), .AW(16), .DW(8), .ROM_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .voice_addr(voice_addr), .voice_active(voice_active),
        .clr_overrun(clr_overrun), .rom_addr(rom_addr0), .rom_en(rom_en0),
        .rom_data(rom_data0), .voice_data(voice_data0), .done(done0),
        .busy(busy0), .overrun(overrun0)
    );

    sample_rom_scheduler #(.NVOICES(2), .AW(16), .DW(8), .ROM_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .voice_addr(voice_addr[31:0]), .voice_active(voice_active[1:0]),
        .clr_overrun(clr_overrun), .rom_addr(rom_addr1), .rom_en(rom_en1),
        .rom_data(rom_data1), .voice_data(voice_data1), .done(done1),
        .busy(busy1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    // ROM contents as a function of address.
    function automatic logic [7:0] romf(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous ROM models; idle cycles return random junk so a capture
    // at the wrong time shows up in the voice data.
    logic [16:0] rp0 = '0;
    logic [16:0] rp1 [3] = '{17'd0, 17'd0, 17'd0};
    logic [7:0]  junk0 = '0, junk1 = '0;
    always @(posedge clk) begin
        rp0    <= {rom_en0, rom_addr0};
        rp1[0] <= {rom_en1, rom_addr1};
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
        junk0  <= 8'($urandom);
        junk1  <= 8'($urandom);
    end
    assign rom_data0 = rp0[16]    ? romf(rp0[15:0])    : junk0;
    assign rom_data1 = rp1[2][16] ? romf(rp1[2][15:0]) : junk1;

    // Common views of both DUTs.
    logic [63:0] w_addr [2], w_en [2], w_done [2], w_busy [2], w_voice [2], w_ov [2];
    assign w_addr[0]  = {48'd0, rom_addr0};
    assign w_addr[1]  = {48'd0, rom_addr1};
    assign w_en[0]    = {63'd0, rom_en0};
    assign w_en[1]    = {63'd0, rom_en1};
    assign w_done[0]  = {63'd0, done0};
    assign w_done[1]  = {63'd0, done1};
    assign w_busy[0]  = {63'd0, busy0};
    assign w_busy[1]  = {63'd0, busy1};
    assign w_voice[0] = {32'd0, voice_data0};
    assign w_voice[1] = {48'd0, voice_data1};
    assign w_ov[0]    = {63'd0, overrun0};
    assign w_ov[1]    = {63'd0, overrun1};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference voice data for one frame: active slots read the ROM, the
    // rest are zero.
    function automatic logic [63:0] exp_voice(input int d, input logic [63:0] a, input logic [3:0] act);
        logic [63:0] v = '0;
        for (int k = 0; k < nv[d]; k++) begin
            if (act[k]) v[k*8 +: 8] = romf(a[k*16 +: 16]);
        end
        return v;
    endfunction

    // One frame: tick in cycle 0, then cycles 1..9 checked on the falling
    // edge. Optional address change in cycle 2, extra tick and clr pulses.
    task automatic applyStimulus(input logic [63:0] a, input logic [3:0] act,
                                 input bit change_addr, input int extra_tick,
                                 input int clr_cycle, input string name);
        logic [63:0] ev [2];
        int          dc;
        logic [63:0] ea;
        logic        ee;
        for (int d = 0; d < 2; d++) ev[d] = exp_voice(d, a, act);
        @(posedge clk); #1;
        sample_tick  = 1'b1;
        voice_addr   = a;
        voice_active = act;
        clr_overrun  = (clr_cycle == 0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput({name, "/idle_busy"}, w_busy[d], 64'd0);
            if (clr_overrun) exp_ov[d] = 1'b0;
        end
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            sample_tick = (c == extra_tick);
            clr_overrun = (c == clr_cycle);
            if (change_addr && c == 2) voice_addr = {$urandom, $urandom};
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                dc = nv[d] + lat[d] + 1;
                ee = (c <= nv[d]) && act[c-1];
                ea = ee ? {48'd0, a[(c-1)*16 +: 16]} : 64'd0;
                checkOutput({name, "/rom_en"},   w_en[d],   {63'd0, ee});
                checkOutput({name, "/rom_addr"}, w_addr[d], ea);
                checkOutput({name, "/done"},     w_done[d], {63'd0, (c == dc)});
                checkOutput({name, "/busy"},     w_busy[d], {63'd0, (c <= dc)});
                checkOutput({name, "/overrun"},  w_ov[d],   {63'd0, exp_ov[d]});
                if (c == dc) last_voice[d] = ev[d];
                checkOutput({name, "/voice"},    w_voice[d], last_voice[d]);
                if (sample_tick && c <= dc) exp_ov[d] = 1'b1;
                else if (clr_overrun) exp_ov[d] = 1'b0;
            end
        end
        @(posedge clk); #1;
        sample_tick = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        logic [63:0] base;
        logic [63:0] ra;
        logic [3:0]  ract;
        base = 64'h0040_0030_0020_0010;

        // Reset state
        #12;
        for (int d = 0; d < 2; d++) begin
            checkOutput("reset/rom_en", w_en[d], 64'd0);
            checkOutput("reset/voice",  w_voice[d], 64'd0);
            checkOutput("reset/busy",   w_busy[d], 64'd0);
            checkOutput("reset/ov",     w_ov[d], 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First tick after reset, all voices active
        applyStimulus(base, 4'b1111, 1'b0, 0, -1, "all_active");
        checkOutput("all_active/value", {32'd0, voice_data0}, 64'h4030_2010);
        // Partial activity
        applyStimulus(base, 4'b0101, 1'b0, 0, -1, "partial");
        checkOutput("partial/value", {32'd0, voice_data0}, 64'h0030_0010);
        // Silent frame
        applyStimulus(base, 4'b0000, 1'b0, 0, -1, "silent");
        // Inputs change mid-frame
        applyStimulus(64'h1234_5678_9ABC_DEF0, 4'b1111, 1'b1, 0, -1, "snapshot");
        // Dropped tick, then clear, then tick and clear together
        applyStimulus(base, 4'b1011, 1'b0, 3, -1, "drop");
        applyStimulus(base, 4'b1110, 1'b0, 0, 2, "clear");
        applyStimulus(base, 4'b0111, 1'b0, 3, 3, "drop_clr");
        applyStimulus(base, 4'b1111, 1'b0, 0, 8, "clear_idle");

        // Reset in the middle of a frame
        @(posedge clk); #1;
        sample_tick  = 1'b1;
        voice_addr   = base;
        voice_active = 4'b1111;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            sample_tick = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput("midreset/rom_en",   w_en[d], 64'd0);
            checkOutput("midreset/rom_addr", w_addr[d], 64'd0);
            checkOutput("midreset/voice",    w_voice[d], 64'd0);
            checkOutput("midreset/done",     w_done[d], 64'd0);
            checkOutput("midreset/busy",     w_busy[d], 64'd0);
            checkOutput("midreset/ov",       w_ov[d], 64'd0);
            last_voice[d] = 64'd0;
            exp_ov[d]     = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                checkOutput("postreset/done", w_done[d], 64'd0);
                checkOutput("postreset/busy", w_busy[d], 64'd0);
            end
        end
        applyStimulus(base, 4'b1111, 1'b0, 0, -1, "after_reset");

        // Randomized frames
        for (int i = 0; i < 12; i++) begin
            ra   = {$urandom, $urandom};
            ract = 4'($urandom);
            applyStimulus(ra, ract, 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                          ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/sample_rom_scheduler.md
SAMPLE_ROM_SCHEDULER -- requirements
Module: sample_rom_scheduler

Interface
REQ-001 SHALL have parameter NVOICES, default 4, number of voice slots sharing the ROM (2..16).
REQ-002 SHALL have parameter AW, default 16, sample-ROM address width.
REQ-003 SHALL have parameter DW, default 8, sample-ROM data width.
REQ-004 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles (1..4).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports below.
REQ-006 clk  input  1  sole clock, all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 sample_tick  input  1  one-cycle pulse, start of an audio sample frame.
REQ-009 voice_addr  input  NVOICES*AW  per-voice playback address, slot k at bits [k*AW +: AW].
REQ-010 voice_active  input  NVOICES  per-voice playing flag.
REQ-011 clr_overrun  input  1  clears the overrun flag.
REQ-012 rom_addr  output  AW  shared ROM address.
REQ-013 rom_en  output  1  ROM read strobe.
REQ-014 rom_data  input  DW  ROM read data, valid ROM_LAT cycles after rom_en.
REQ-015 voice_data  output  NVOICES*DW  per-voice sample for the current frame, slot k at [k*DW +: DW].
REQ-016 done  output  1  one-cycle pulse, new voice_data valid.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 overrun  output  1  sticky, a sample_tick was dropped.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on sample_tick, ISSUE->DRAIN after NVOICES cycles, DRAIN->IDLE-bound DONE after ROM_LAT cycles, DONE->IDLE after 1 cycle.
REQ-020 SHALL snapshot voice_addr and voice_active on the edge accepting sample_tick; later input changes do not affect the frame in progress.
REQ-021 In ISSUE cycle k (k=0..NVOICES-1) SHALL drive rom_addr = snapshot address of slot k and rom_en = snapshot active bit of slot k.
REQ-022 SHALL drive rom_addr = 0 and rom_en = 0 in all cycles where no active slot is being issued.
REQ-023 SHALL capture rom_data ROM_LAT cycles after each rom_en into slot k; inactive slots SHALL get value 0 with no ROM access.
REQ-024 SHALL update all NVOICES voice_data slots together on the edge entering DONE; voice_data SHALL otherwise hold.
REQ-025 done SHALL be high exactly during the DONE cycle; with sample_tick at cycle T, done is high at cycle T+NVOICES+ROM_LAT+1.
REQ-026 sample_tick SHALL be accepted only in IDLE; a tick in ISSUE, DRAIN or DONE SHALL be dropped and set overrun.
REQ-027 clr_overrun SHALL clear overrun; if a drop occurs in the same cycle, set SHALL win.
REQ-028 A frame with no active voices SHALL still run full length and pulse done with all voice_data = 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, rom_addr=0, rom_en=0, voice_data=0, done=0, busy=0, overrun=0, and clear snapshot/shadow registers.
REQ-030 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL follow reset release.
REQ-031 The first sample_tick after rst_n release SHALL be accepted normally.

Verification
REQ-032 Defaults, all active, addr slots 0x0010/0x0020/0x0030/0x0040, ROM data = addr[7:0], tick at cycle 0 -> rom_en cycles 1-4 with those addresses, done at cycle 6, voice_data = 0x40302010.
REQ-033 voice_active=4'b0101, same setup -> rom_en only in cycles 1 and 3, voice_data = 0x00300010, done at cycle 6.
REQ-034 Change voice_addr at cycle 2 of a frame -> rom_addr still shows tick-time snapshot values.
REQ-035 Second tick at cycle 3 -> no new frame, overrun=1 from cycle 4; clr_overrun pulse -> overrun=0; tick plus clr in same cycle during busy -> overrun stays 1.
REQ-036 rst_n low at cycle 3 of a frame -> all outputs reset asynchronously, no done after release, next tick gives normal frame.
REQ-037 ROM_LAT=3, NVOICES=2 -> done 6 cycles after tick, correct per-slot capture alignment.
